panel_stream_receiver: RTL and testbench

Receiving end of the cube's LED panel drive interface: captures the serial stream (serial_clk, latch_enable, output_enable_n, 12 serial data lines, 16 active-low row selects) exactly as a panel's shift-register chain would. It rebuilds the latched frame per row into a readable buffer and flags protocol violations. It sits on the test-panel GPIO header, either looped back from the controller outputs or wired to a second board, for bring-up and regression of the panel driver.

---
 rtl/panel_stream_receiver.sv | 152 +++++++++++++++
 tb/tb_panel_stream_receiver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/panel_stream_receiver.sv
// Panel shift-chain receiver: synchronises the LED panel drive stream, rebuilds
// each latched row into a readback buffer and raises sticky protocol flags.
module panel_stream_receiver #(
  parameter int CHAIN_BITS = 16,
  parameter int ROWS       = 16,
  parameter int LINES      = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  serial_clk,
  input  logic                  latch_enable,
  input  logic                  output_enable_n,
  input  logic [LINES-1:0]      serial_data_in,
  input  logic [ROWS-1:0]       row_select_n,
  input  logic [3:0]            rd_row,
  input  logic [3:0]            rd_line,
  output logic [CHAIN_BITS-1:0] rd_data,
  output logic                  frame_done,
  output logic [7:0]            last_bit_count,
  output logic                  count_error,
  output logic                  row_error,
  output logic                  blank_violation,
  input  logic                  clear_errors
);

  localparam int RW = $clog2(ROWS);

  logic                  r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic                  r_latch_p0, r_latch_p1, r_latch_p2;
  logic                  r_oen_p0, r_oen_p1;
  logic [LINES-1:0]      r_data_p0, r_data_p1;
  logic [ROWS-1:0]       r_row_p0, r_row_p1;

  logic [CHAIN_BITS-1:0] r_sr  [LINES];
  logic [CHAIN_BITS-1:0] r_buf [ROWS][LINES];
  logic [7:0]            r_bit_cnt;
  logic [7:0]            r_last;
  logic                  r_fd_pend, r_frame_done;
  logic                  r_count_err, r_row_err, r_blank_err;
  logic [CHAIN_BITS-1:0] r_rd_data;

  logic                  w_shift, w_latch, w_row_ok;
  logic [ROWS-1:0]       w_row_low;
  logic [RW-1:0]         w_row_idx;
  logic [7:0]            w_cnt_next;
  logic [CHAIN_BITS-1:0] w_sr_next [LINES];
  logic [CHAIN_BITS-1:0] w_rd;

  // Stage p0/p1: two-flop synchronisers; p2: previous copy for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_p0  <= 1'b0;
      r_sclk_p1  <= 1'b0;
      r_sclk_p2  <= 1'b0;
      r_latch_p0 <= 1'b0;
      r_latch_p1 <= 1'b0;
      r_latch_p2 <= 1'b0;
      r_oen_p0   <= 1'b1;
      r_oen_p1   <= 1'b1;
      r_data_p0  <= '0;
      r_data_p1  <= '0;
      r_row_p0   <= '1;
      r_row_p1   <= '1;
    end else begin
      r_sclk_p0  <= serial_clk;
      r_sclk_p1  <= r_sclk_p0;
      r_sclk_p2  <= r_sclk_p1;
      r_latch_p0 <= latch_enable;
      r_latch_p1 <= r_latch_p0;
      r_latch_p2 <= r_latch_p1;
      r_oen_p0   <= output_enable_n;
      r_oen_p1   <= r_oen_p0;
      r_data_p0  <= serial_data_in;
      r_data_p1  <= r_data_p0;
      r_row_p0   <= row_select_n;
      r_row_p1   <= r_row_p0;
    end
  end

  assign w_shift   = r_sclk_p1 & ~r_sclk_p2;
  assign w_latch   = r_latch_p1 & ~r_latch_p2;
  assign w_row_low = ~r_row_p1;
  assign w_row_ok  = (w_row_low != '0) && ((w_row_low & (w_row_low - ROWS'(1))) == '0);

  // A same-cycle latch sees the post-shift registers and count
  always_comb begin
    w_cnt_next = r_bit_cnt;
    if (w_shift && r_bit_cnt != 8'hFF) w_cnt_next = r_bit_cnt + 8'd1;
    for (int i = 0; i < LINES; i++) begin
      w_sr_next[i] = r_sr[i];
      if (w_shift) w_sr_next[i] = {r_sr[i][CHAIN_BITS-2:0], r_data_p1[i]};
    end
    w_row_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_row_low[r]) w_row_idx = RW'(r);
    end
  end

  always_comb begin
    w_rd = '0;
    if (32'(rd_row) < ROWS && 32'(rd_line) < LINES) begin
      if (w_latch && w_row_ok && w_row_idx == RW'(rd_row)) w_rd = w_sr_next[rd_line];
      else                                                   w_rd = r_buf[rd_row][rd_line];
    end
  end

  // Stage p3: shift, commit, flags and readback register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) r_sr[i] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int i = 0; i < LINES; i++) r_buf[r][i] <= '0;
      r_bit_cnt    <= '0;
      r_last       <= '0;
      r_fd_pend    <= 1'b0;
      r_frame_done <= 1'b0;
      r_count_err  <= 1'b0;
      r_row_err    <= 1'b0;
      r_blank_err  <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_sr      <= w_sr_next;
      r_rd_data <= w_rd;
      if (w_latch) begin
        r_bit_cnt <= '0;
        r_last    <= w_cnt_next;
        if (w_row_ok) r_buf[w_row_idx] <= w_sr_next;
      end else begin
        r_bit_cnt <= w_cnt_next;
      end
      r_fd_pend    <= w_latch && w_row_ok && (w_row_idx == RW'(ROWS-1));
      r_frame_done <= r_fd_pend;
      if (clear_errors) begin
        r_count_err <= 1'b0;
        r_row_err   <= 1'b0;
        r_blank_err <= 1'b0;
      end else if (w_latch) begin
        if (w_cnt_next != 8'(CHAIN_BITS)) r_count_err <= 1'b1;
        if (!w_row_ok)                    r_row_err   <= 1'b1;
        if (!r_oen_p1)                    r_blank_err <= 1'b1;
      end
    end
  end

  assign rd_data         = r_rd_data;
  assign frame_done      = r_frame_done;
  assign last_bit_count  = r_last;
  assign count_error     = r_count_err;
  assign row_error       = r_row_err;
  assign blank_violation = r_blank_err;

endmodule

// File: tb/tb_panel_stream_receiver.sv
// Randomised bench for panel_stream_receiver against a word-level model of the
// panel chain: last 16 bits per line, latched row buffer and protocol flags.
module tb_panel_stream_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        serial_clk, latch_enable, output_enable_n, clear_errors;
  logic [11:0] serial_data_in;
  logic [15:0] row_select_n;
  logic [3:0]  rd_row, rd_line;
  logic [15:0] rd_data;
  logic        frame_done, count_error, row_error, blank_violation;
  logic [7:0]  last_bit_count;

  panel_stream_receiver #(.CHAIN_BITS(16), .ROWS(16), .LINES(12)) dut (
    .clk(clk), .reset_n(reset_n), .serial_clk(serial_clk), .latch_enable(latch_enable),
    .output_enable_n(output_enable_n), .serial_data_in(serial_data_in),
    .row_select_n(row_select_n), .rd_row(rd_row), .rd_line(rd_line), .rd_data(rd_data),
    .frame_done(frame_done), .last_bit_count(last_bit_count), .count_error(count_error),
    .row_error(row_error), .blank_violation(blank_violation), .clear_errors(clear_errors)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int latch_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) begin fd_count++; fd_cyc = cyc; end

  // Reference model: last 16 bits seen per line, buffer, counters, flags
  logic [15:0] m_sr  [12];
  logic [15:0] m_buf [16][12];
  int          m_cnt, m_last, m_fd;
  bit          m_ce, m_re, m_bv;
  logic [15:0] tw [12];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 12; i++) m_sr[i] = 16'h0;
    for (int r = 0; r < 16; r++) for (int i = 0; i < 12; i++) m_buf[r][i] = 16'h0;
    m_cnt = 0; m_last = 0; m_ce = 0; m_re = 0; m_bv = 0;
  endtask

  task automatic model_shift(input logic [11:0] d);
    for (int i = 0; i < 12; i++) m_sr[i] = 16'((m_sr[i] * 2 + d[i]) % 65536);
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_latch(input logic [15:0] row_n, input logic oe_n);
    int zeros = 0;
    int idx = 0;
    for (int b = 0; b < 16; b++) if (!row_n[b]) begin zeros++; idx = b; end
    if (zeros == 1) begin
      for (int i = 0; i < 12; i++) m_buf[idx][i] = m_sr[i];
      if (idx == 15) m_fd++;
    end else m_re = 1;
    m_last = m_cnt;
    if (m_cnt != 16) m_ce = 1;
    m_cnt = 0;
    if (!oe_n) m_bv = 1;
  endtask

  function automatic logic [11:0] tw_bits(input int b);
    logic [11:0] v;
    for (int i = 0; i < 12; i++) v[i] = tw[i][b];
    return v;
  endfunction

  task automatic randomize_tw();
    for (int i = 0; i < 12; i++) tw[i] = 16'($urandom);
  endtask

  task automatic pin_shift(input logic [11:0] d);
    @(negedge clk) serial_data_in = d;
    repeat (4) @(negedge clk);
    serial_clk = 1'b1;
    model_shift(d);
    repeat (4) @(negedge clk);
    serial_clk = 1'b0;
  endtask

  // MSB first: the first bit shifted ends up at the top of the word
  task automatic shift_tw(input int nbits);
    for (int b = 15; b > 15 - nbits; b--) pin_shift(tw_bits(b));
  endtask

  task automatic pin_latch(input logic [15:0] row_n, input logic oe_n, input bit with_shift,
                           input logic [11:0] d);
    @(negedge clk);
    row_select_n = row_n; output_enable_n = oe_n;
    if (with_shift) serial_data_in = d;
    repeat (4) @(negedge clk);
    latch_enable = 1'b1;
    latch_cyc = cyc;
    if (with_shift) begin serial_clk = 1'b1; model_shift(d); end
    model_latch(row_n, oe_n);
    repeat (4) @(negedge clk);
    latch_enable = 1'b0; serial_clk = 1'b0;
    repeat (4) @(negedge clk);
    row_select_n = '1; output_enable_n = 1'b1;
  endtask

  task automatic rd(input int r, input int l, output logic [15:0] v);
    @(negedge clk);
    rd_row = 4'(r); rd_line = 4'(l);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic read_check_all(input string tag);
    logic [15:0] v;
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++) begin
        rd(r, l, v);
        check_val($sformatf("%s_r%0d_l%0d", tag, r, l), 32'(v), (l < 12) ? 32'(m_buf[r][l]) : 32'h0);
      end
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, "_last"}, 32'(last_bit_count), 32'(m_last));
    check_val({tag, "_cerr"}, 32'(count_error), 32'(m_ce));
    check_val({tag, "_rerr"}, 32'(row_error), 32'(m_re));
    check_val({tag, "_blank"}, 32'(blank_violation), 32'(m_bv));
    check_val({tag, "_fdcnt"}, 32'(fd_count), 32'(m_fd));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int fd_before;
    reset_n = 1'b0; serial_clk = 1'b0; latch_enable = 1'b0; output_enable_n = 1'b1;
    serial_data_in = '0; row_select_n = '1; rd_row = '0; rd_line = '0; clear_errors = 1'b0;
    m_fd = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_rd", 32'(rd_data), 0);
    check_val("rst_fd", 32'(frame_done), 0);
    check_flags("rst");
    reset_n = 1'b1;
    read_check_all("rst_buf");

    randomize_tw();
    tw[0] = 16'hA5C3; tw[11] = 16'h1234;
    shift_tw(16);
    pin_latch(16'hFFFB, 1'b1, 0, '0);
    rd(2, 0, v);  check_val("row2_l0", 32'(v), 32'hA5C3);
    rd(2, 11, v); check_val("row2_l11", 32'(v), 32'h1234);
    check_val("row2_last", 32'(last_bit_count), 16);
    check_flags("row2");

    fd_before = fd_count;
    for (int r = 0; r < 16; r++) begin
      randomize_tw();
      shift_tw(16);
      pin_latch(~(16'h1 << r), 1'b1, 0, '0);
    end
    check_val("frame_fd_once", 32'(fd_count - fd_before), 1);
    check_val("frame_fd_lat", 32'(fd_cyc - latch_cyc), 4);
    check_flags("frame");
    read_check_all("frame");

    randomize_tw();
    shift_tw(15);
    pin_latch(16'hFFDF, 1'b1, 0, '0);
    check_val("short_cerr", 32'(count_error), 1);
    check_val("short_last", 32'(last_bit_count), 15);
    check_flags("short");
    pin_latch(16'hFFFC, 1'b1, 0, '0);
    check_val("badrow_rerr", 32'(row_error), 1);
    check_flags("badrow");
    read_check_all("badrow");
    @(negedge clk) clear_errors = 1'b1;
    @(negedge clk) clear_errors = 1'b0;
    m_ce = 0; m_re = 0; m_bv = 0;
    check_flags("clear");

    randomize_tw();
    shift_tw(16);
    pin_latch(16'hBFFF, 1'b0, 0, '0);
    check_val("blank_set", 32'(blank_violation), 1);
    check_flags("blank");

    randomize_tw();
    shift_tw(15);
    pin_latch(16'hFF7F, 1'b1, 1, tw_bits(0));
    check_val("simul_last", 32'(last_bit_count), 16);
    rd(7, 4, v); check_val("simul_word", 32'(v), 32'(tw[4]));
    check_flags("simul");

    randomize_tw();
    shift_tw(8);
    @(negedge clk) reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_flags("mid_rst");
    read_check_all("mid_rst");
    randomize_tw();
    shift_tw(16);
    pin_latch(16'hFFF7, 1'b1, 0, '0);
    check_val("post_rst_last", 32'(last_bit_count), 16);
    rd(3, 9, v); check_val("post_rst_word", 32'(v), 32'(tw[9]));
    check_flags("post_rst");
    read_check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
